// File: rtl/if_stage_5stage.sv
// LEGv8 instruction-fetch stage with IF/ID pipeline register.
// ROM contents come from IMEM_IMAGE (word i at bits [i*INST_WIDTH +: INST_WIDTH]).
module if_stage_5stage #(
  parameter int unsigned PC_WIDTH   = 64,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [INST_WIDTH-1:0] NOP_ENC = 32'hD503201F,
  parameter logic [IMEM_DEPTH*INST_WIDTH-1:0] IMEM_IMAGE = {IMEM_DEPTH{NOP_ENC}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic [PC_WIDTH-1:0]   PCOUT,
  output logic [INST_WIDTH-1:0] INST,
  output logic [PC_WIDTH-1:0]   pc_IF_ID,
  output logic [INST_WIDTH-1:0] inst_IF_ID,
  output logic                  valid_IF_ID,
  output logic [31:0]           fetch_count
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic [INST_WIDTH-1:0] rom_s [IMEM_DEPTH];
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   if_pc_q, if_pc_d;
  logic [INST_WIDTH-1:0] if_inst_q, if_inst_d;
  logic                  if_valid_q, if_valid_d;
  logic [31:0]           fetch_cnt_q, fetch_cnt_d;
  logic [INST_WIDTH-1:0] inst_s;
  logic [PC_WIDTH-1:0]   target_s;

  for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_rom
    assign rom_s[i] = IMEM_IMAGE[i*INST_WIDTH +: INST_WIDTH];
  end

  // Addresses beyond the ROM read as a bubble rather than aliasing.
  always_comb begin
    inst_s = NOP_ENC;
    if (~|pc_q[PC_WIDTH-1:AW+2]) begin
      inst_s = rom_s[pc_q[AW+1:2]];
    end else begin
      inst_s = NOP_ENC;
    end
  end

  assign target_s = branch_target & ~{{(PC_WIDTH-2){1'b0}}, 2'b11};

  // Next-state: redirect/flush beats stall, stall beats sequential fetch.
  always_comb begin
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = if_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    if (branch_taken) begin
      pc_d       = target_s;
      if_pc_d    = {PC_WIDTH{1'b0}};
      if_inst_d  = NOP_ENC;
      if_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d       = pc_q + {{(PC_WIDTH-3){1'b0}}, 3'b100};
      if_pc_d    = pc_q;
      if_inst_d  = inst_s;
      if_valid_d = 1'b1;
      if (fetch_cnt_q != 32'hFFFF_FFFF) begin
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end else begin
        fetch_cnt_d = fetch_cnt_q;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= {PC_WIDTH{1'b0}};
      if_pc_q     <= {PC_WIDTH{1'b0}};
      if_inst_q   <= NOP_ENC;
      if_valid_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign PCOUT       = pc_q;
  assign INST        = inst_s;
  assign pc_IF_ID    = if_pc_q;
  assign inst_IF_ID  = if_inst_q;
  assign valid_IF_ID = if_valid_q;
  assign fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage_5stage.sv
// Directed bench for if_stage_5stage: ROM[i] = 8B000000 + i, outputs sampled on the falling edge.
module tb_if_stage_5stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  function automatic logic [64*32-1:0] mk_image();
    logic [64*32-1:0] img;
    img = '0;
    for (int i = 0; i < 64; i++) img[i*32 +: 32] = 32'h8B000000 + 32'(i);
    return img;
  endfunction

  localparam logic [64*32-1:0] IMG = mk_image();

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'd0;
  logic [63:0] PCOUT;
  logic [31:0] INST;
  logic [63:0] pc_IF_ID;
  logic [31:0] inst_IF_ID;
  logic        valid_IF_ID;
  logic [31:0] fetch_count;

  int total = 0;
  int bad = 0;

  if_stage_5stage #(.IMEM_IMAGE(IMG)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .PCOUT(PCOUT), .INST(INST),
    .pc_IF_ID(pc_IF_ID), .inst_IF_ID(inst_IF_ID), .valid_IF_ID(valid_IF_ID),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #28 rst = 1'b0;
    @(negedge clk);
    total++; if (PCOUT !== 64'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", PCOUT); end
    total++; if (INST !== 32'h8B000000) begin bad++; $display("FAIL reset_inst got=%h exp=8b000000", INST); end
    total++; if (pc_IF_ID !== 64'd0) begin bad++; $display("FAIL reset_pc_ifid got=%h exp=0", pc_IF_ID); end
    total++; if (inst_IF_ID !== NOP) begin bad++; $display("FAIL reset_inst_ifid got=%h exp=%h", inst_IF_ID, NOP); end
    total++; if (valid_IF_ID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_IF_ID); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 2; k++) begin
      step();
      total++; if (PCOUT !== 64'(4*k)) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, PCOUT, 64'(4*k)); end
      total++; if (inst_IF_ID !== 32'h8B000000 + 32'(k-1)) begin bad++; $display("FAIL seq_inst[%0d] got=%h exp=%h", k, inst_IF_ID, 32'h8B000000 + 32'(k-1)); end
      total++; if (pc_IF_ID !== 64'(4*(k-1))) begin bad++; $display("FAIL seq_pcifid[%0d] got=%h exp=%h", k, pc_IF_ID, 64'(4*(k-1))); end
      total++; if (valid_IF_ID !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", k, valid_IF_ID); end
      total++; if (fetch_count !== 32'(k)) begin bad++; $display("FAIL seq_cnt[%0d] got=%0d exp=%0d", k, fetch_count, k); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (PCOUT !== 64'h8) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=8", k, PCOUT); end
      total++; if (inst_IF_ID !== 32'h8B000001) begin bad++; $display("FAIL stall_inst[%0d] got=%h exp=8b000001", k, inst_IF_ID); end
      total++; if (pc_IF_ID !== 64'h4) begin bad++; $display("FAIL stall_pcifid[%0d] got=%h exp=4", k, pc_IF_ID); end
      total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL stall_cnt[%0d] got=%0d exp=2", k, fetch_count); end
    end
    stall = 1'b0;
    step();
    total++; if (PCOUT !== 64'hC) begin bad++; $display("FAIL unstall_pc got=%h exp=c", PCOUT); end
    total++; if (inst_IF_ID !== 32'h8B000002) begin bad++; $display("FAIL unstall_inst got=%h exp=8b000002", inst_IF_ID); end
    total++; if (pc_IF_ID !== 64'h8) begin bad++; $display("FAIL unstall_pcifid got=%h exp=8", pc_IF_ID); end
    total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL unstall_cnt got=%0d exp=3", fetch_count); end
  endtask

  task automatic test_branch_flush();
    branch_taken = 1'b1; branch_target = 64'h20;
    step();
    branch_taken = 1'b0;
    total++; if (PCOUT !== 64'h20) begin bad++; $display("FAIL br_pc got=%h exp=20", PCOUT); end
    total++; if (inst_IF_ID !== NOP) begin bad++; $display("FAIL br_inst got=%h exp=%h", inst_IF_ID, NOP); end
    total++; if (pc_IF_ID !== 64'd0) begin bad++; $display("FAIL br_pcifid got=%h exp=0", pc_IF_ID); end
    total++; if (valid_IF_ID !== 1'b0) begin bad++; $display("FAIL br_valid got=%b exp=0", valid_IF_ID); end
    total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL br_cnt got=%0d exp=3", fetch_count); end
    step();
    total++; if (PCOUT !== 64'h24) begin bad++; $display("FAIL br2_pc got=%h exp=24", PCOUT); end
    total++; if (inst_IF_ID !== 32'h8B000008) begin bad++; $display("FAIL br2_inst got=%h exp=8b000008", inst_IF_ID); end
    total++; if (pc_IF_ID !== 64'h20) begin bad++; $display("FAIL br2_pcifid got=%h exp=20", pc_IF_ID); end
    total++; if (valid_IF_ID !== 1'b1) begin bad++; $display("FAIL br2_valid got=%b exp=1", valid_IF_ID); end
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL br2_cnt got=%0d exp=4", fetch_count); end
  endtask

  task automatic test_simultaneous();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h13;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    total++; if (PCOUT !== 64'h10) begin bad++; $display("FAIL sim_pc got=%h exp=10", PCOUT); end
    total++; if (inst_IF_ID !== NOP) begin bad++; $display("FAIL sim_inst got=%h exp=%h", inst_IF_ID, NOP); end
    total++; if (valid_IF_ID !== 1'b0) begin bad++; $display("FAIL sim_valid got=%b exp=0", valid_IF_ID); end
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL sim_cnt got=%0d exp=4", fetch_count); end
    step();
    total++; if (PCOUT !== 64'h14) begin bad++; $display("FAIL sim2_pc got=%h exp=14", PCOUT); end
    total++; if (inst_IF_ID !== 32'h8B000004) begin bad++; $display("FAIL sim2_inst got=%h exp=8b000004", inst_IF_ID); end
    total++; if (pc_IF_ID !== 64'h10) begin bad++; $display("FAIL sim2_pcifid got=%h exp=10", pc_IF_ID); end
    total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL sim2_cnt got=%0d exp=5", fetch_count); end
  endtask

  task automatic test_boundaries();
    branch_taken = 1'b1; branch_target = 64'hFC;
    step();
    total++; if (INST !== 32'h8B00003F) begin bad++; $display("FAIL last_word got=%h exp=8b00003f", INST); end
    branch_target = 64'h100;
    step();
    branch_taken = 1'b0;
    total++; if (PCOUT !== 64'h100) begin bad++; $display("FAIL oor_pc got=%h exp=100", PCOUT); end
    total++; if (INST !== NOP) begin bad++; $display("FAIL oor_inst got=%h exp=%h", INST, NOP); end
    step();
    total++; if (inst_IF_ID !== NOP) begin bad++; $display("FAIL oor_ifid got=%h exp=%h", inst_IF_ID, NOP); end
    total++; if (valid_IF_ID !== 1'b1) begin bad++; $display("FAIL oor_valid got=%b exp=1", valid_IF_ID); end
    total++; if (pc_IF_ID !== 64'h100) begin bad++; $display("FAIL oor_pcifid got=%h exp=100", pc_IF_ID); end
    total++; if (fetch_count !== 32'd6) begin bad++; $display("FAIL oor_cnt got=%0d exp=6", fetch_count); end
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    branch_taken = 1'b0;
    total++; if (PCOUT !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL top_pc got=%h exp=fffffffffffffffc", PCOUT); end
    step();
    total++; if (PCOUT !== 64'd0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", PCOUT); end
    total++; if (pc_IF_ID !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_pcifid got=%h exp=fffffffffffffffc", pc_IF_ID); end
    total++; if (fetch_count !== 32'd7) begin bad++; $display("FAIL wrap_cnt got=%0d exp=7", fetch_count); end
    step();
    total++; if (inst_IF_ID !== 32'h8B000000) begin bad++; $display("FAIL wrap_inst got=%h exp=8b000000", inst_IF_ID); end
    total++; if (PCOUT !== 64'h4) begin bad++; $display("FAIL wrap2_pc got=%h exp=4", PCOUT); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) step();
    total++; if (PCOUT !== 64'h18) begin bad++; $display("FAIL pre_rst_pc got=%h exp=18", PCOUT); end
    total++; if (fetch_count !== 32'd13) begin bad++; $display("FAIL pre_rst_cnt got=%0d exp=13", fetch_count); end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h40;
    #2 rst = 1'b1;
    #1;
    total++; if (PCOUT !== 64'd0) begin bad++; $display("FAIL arst_pc got=%h exp=0", PCOUT); end
    total++; if (INST !== 32'h8B000000) begin bad++; $display("FAIL arst_inst got=%h exp=8b000000", INST); end
    total++; if (pc_IF_ID !== 64'd0) begin bad++; $display("FAIL arst_pcifid got=%h exp=0", pc_IF_ID); end
    total++; if (inst_IF_ID !== NOP) begin bad++; $display("FAIL arst_instifid got=%h exp=%h", inst_IF_ID, NOP); end
    total++; if (valid_IF_ID !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", valid_IF_ID); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", fetch_count); end
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    total++; if (PCOUT !== 64'd0) begin bad++; $display("FAIL arst_hold_pc got=%h exp=0", PCOUT); end
    step();
    total++; if (PCOUT !== 64'h4) begin bad++; $display("FAIL post_rst_pc got=%h exp=4", PCOUT); end
    total++; if (inst_IF_ID !== 32'h8B000000) begin bad++; $display("FAIL post_rst_inst got=%h exp=8b000000", inst_IF_ID); end
    total++; if (pc_IF_ID !== 64'd0) begin bad++; $display("FAIL post_rst_pcifid got=%h exp=0", pc_IF_ID); end
    total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL post_rst_cnt got=%0d exp=1", fetch_count); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_flush();
    test_simultaneous();
    test_boundaries();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
